// File: rtl/timer_ctrl.sv
// Countdown timer sequencer for an external four-digit BCD (MM:SS) down counter.
// The timer does not store the time. It reads the external digits and issues
// registered decrement, load and clear strobes back to them.
module timer_ctrl #(
    parameter int TICK_DIV  = 50000000,
    parameter int ALARM_CYC = 8
) (
    input  logic       clk_i,
    input  logic       init_i,
    input  logic       start_i,
    input  logic       pause_i,
    input  logic       cancel_i,
    input  logic [3:0] d_su_i,
    input  logic [3:0] d_st_i,
    input  logic [3:0] d_mu_i,
    input  logic [3:0] d_mt_i,
    output logic [3:0] dec_o,
    output logic       set_st5_o,
    output logic       clr_o,
    output logic       running_o,
    output logic       paused_o,
    output logic       alarm_o
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int AW = $clog2(ALARM_CYC + 1);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [AW-1:0] ALARM_MAX = AW'(ALARM_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PAUSE,
        S_ALARM
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [AW-1:0] acnt_q, acnt_d;
    logic [3:0]    dec_q, dec_d;
    logic          set_q, set_d;
    logic          clr_q, clr_d;

    // Digit order is su, st, mu, mt. This matches the dec bit order.
    logic [3:0] digit [4];
    logic [3:0] digit_zero;
    logic       all_zero;
    logic       last_step;
    logic       step_cycle;
    logic [3:0] step_dec;
    logic       step_set;

    assign digit[0] = d_su_i;
    assign digit[1] = d_st_i;
    assign digit[2] = d_mu_i;
    assign digit[3] = d_mt_i;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_zero
            assign digit_zero[gi] = (digit[gi] == 4'd0);
        end
    endgenerate

    assign all_zero   = &digit_zero;
    assign last_step  = (d_su_i == 4'd1) && (&digit_zero[3:1]);
    assign step_cycle = (presc_q == PRESC_MAX);

    // A borrow ripples upward: each digit decrements when all lower digits are 0.
    // The seconds-tens digit wraps to 5, so it is reloaded instead of decremented.
    assign step_dec[0] = 1'b1;
    assign step_dec[1] = digit_zero[0] && !digit_zero[1];
    assign step_dec[2] = digit_zero[0] && digit_zero[1];
    assign step_dec[3] = digit_zero[0] && digit_zero[1] && digit_zero[2];
    assign step_set    = digit_zero[0] && digit_zero[1];

    // Next-state logic and strobe decode. Input priority is cancel, then pause, then start.
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        acnt_d  = acnt_q;
        dec_d   = 4'd0;
        set_d   = 1'b0;
        clr_d   = 1'b0;
        if (cancel_i) begin
            state_d = S_IDLE;
            presc_d = '0;
            acnt_d  = '0;
            clr_d   = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!pause_i && start_i && !all_zero) begin
                        state_d = S_RUN;
                        presc_d = '0;
                    end
                end
                S_RUN: begin
                    if (all_zero) begin
                        state_d = S_ALARM;
                        acnt_d  = '0;
                    end else begin
                        presc_d = step_cycle ? '0 : presc_q + 1'b1;
                        if (step_cycle) begin
                            dec_d = step_dec;
                            set_d = step_set;
                        end
                        if (step_cycle && last_step) begin
                            state_d = S_ALARM;
                            acnt_d  = '0;
                        end else if (pause_i) begin
                            state_d = S_PAUSE;
                            // If pause arrives in a step cycle, that step has already been
                            // issued. The prescaler still wraps so that resuming does not repeat the step.
                            if (!step_cycle) begin
                                presc_d = presc_q;
                            end
                        end
                    end
                end
                S_PAUSE: begin
                    if (!pause_i && start_i) begin
                        state_d = S_RUN;
                    end
                end
                S_ALARM: begin
                    if (!pause_i && start_i) begin
                        state_d = S_IDLE;
                        acnt_d  = '0;
                    end else if (acnt_q == ALARM_MAX) begin
                        state_d = S_IDLE;
                        acnt_d  = '0;
                    end else begin
                        acnt_d = acnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    presc_d = '0;
                    acnt_d  = '0;
                end
            endcase
        end
    end

    // State and strobe registers. init forces IDLE and keeps clr high while it is held.
    always_ff @(posedge clk_i) begin
        if (init_i) begin
            state_q <= S_IDLE;
            presc_q <= '0;
            acnt_q  <= '0;
            dec_q   <= 4'd0;
            set_q   <= 1'b0;
            clr_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            acnt_q  <= acnt_d;
            dec_q   <= dec_d;
            set_q   <= set_d;
            clr_q   <= clr_d;
        end
    end

    assign dec_o     = dec_q;
    assign set_st5_o = set_q;
    assign clr_o     = clr_q;
    assign running_o = (state_q == S_RUN);
    assign paused_o  = (state_q == S_PAUSE);
    assign alarm_o   = (state_q == S_ALARM);

endmodule

// File: doc/timer_ctrl.md
TIMER_CTRL -- requirements
Module: timer_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 50000000: clk cycles per countdown step (>=2).
REQ-002 Parameter ALARM_CYC, default 8: clk cycles alarm is held before auto-return to IDLE (>=1).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 init  in  1  reset, synchronous, active-high.
REQ-005 start  in  1  level sampled each cycle; starts from IDLE or resumes from PAUSE.
REQ-006 pause  in  1  level sampled each cycle; suspends counting.
REQ-007 cancel  in  1  level sampled each cycle; aborts to IDLE.
REQ-008 d_su, d_st, d_mu, d_mt  in  4 each  current BCD digits from external 9-0 down counters: seconds units, seconds tens, minutes units, minutes tens.
REQ-009 dec  out  4  one-cycle decrement strobes, bit0=su, bit1=st, bit2=mu, bit3=mt; an external digit wraps 0->9 on decrement.
REQ-010 set_st5  out  1  one-cycle strobe loading seconds-tens digit with 5.
REQ-011 clr  out  1  strobe clearing all four digits to 0.
REQ-012 running, paused, alarm  out  1 each  status levels.

Function
REQ-013 FSM states IDLE, RUN, PAUSE, ALARM; one-hot or encoded, not visible on ports.
REQ-014 Input priority each cycle: cancel > pause > start.
REQ-015 IDLE: start=1 with any digit nonzero -> RUN, prescaler cleared to 0; start=1 with all digits 0 -> remain IDLE, no strobes.
REQ-016 RUN: prescaler increments each cycle, 0..TICK_DIV-1, wrapping to 0; cycle N with prescaler=TICK_DIV-1 is the step cycle.
REQ-017 Digits are sampled in step cycle N; strobes are registered and asserted only in cycle N+1, for exactly one cycle.
REQ-018 Step decode: dec[0]=1; dec[1]=(su==0 && st!=0); set_st5=(su==0 && st==0); dec[2]=(su==0 && st==0); dec[3]=(su==0 && st==0 && mu==0).
REQ-019 If sampled digits equal 00:01 in step cycle, the step is issued and state -> ALARM in cycle N+1.
REQ-020 If all sampled digits are 0 in any RUN cycle, no strobe is issued and state -> ALARM next cycle.
REQ-021 RUN: pause=1 -> PAUSE; prescaler holds value; a step cycle coinciding with pause still issues its strobes.
REQ-022 PAUSE: start=1 -> RUN, prescaler resumes from held value; pause=1 alone has no effect.
REQ-023 ALARM: alarm=1 for ALARM_CYC cycles, then IDLE; start=1 exits to IDLE early; no strobes in ALARM.
REQ-024 cancel=1 in any state -> IDLE next cycle, prescaler 0, clr=1 for exactly one cycle; pending step strobes are suppressed.
REQ-025 running=1 only in RUN, paused=1 only in PAUSE, alarm=1 only in ALARM; exactly one of these or none (IDLE).
REQ-026 dec, set_st5 never asserted outside the cycle following a RUN step cycle; clr and dec never both nonzero in one cycle.

Reset
REQ-027 init=1 at a clock edge -> state IDLE, prescaler 0, alarm counter 0, dec=0, set_st5=0, running=paused=alarm=0, clr=1 for every cycle init is held.
REQ-028 init overrides all other inputs, including mid-RUN and mid-ALARM; first cycle after init release clr=0.

Verification (TICK_DIV=4, ALARM_CYC=8)
REQ-029 init 2 cycles -> clr=1 both cycles, all other outputs 0; then IDLE, clr=0.
REQ-030 digits 00:01, start 1 cycle -> running=1; dec=0001 exactly once, 4 cycles after RUN entry; alarm=1 same cycle, held 8 cycles, then all status 0.
REQ-031 digits 01:00 at step -> dec=0101, set_st5=1, dec[1]=0, dec[3]=0 in one cycle.
REQ-032 digits 10:00 at step -> dec=1101, set_st5=1.
REQ-033 pause at prescaler=2, hold 10 cycles, then start -> no strobes while paused; step strobe 2 cycles after resume.
REQ-034 digits 00:00 + start -> stays IDLE, no strobes; cancel during RUN -> clr=1 one cycle, IDLE, no pending dec.
